// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC turning a Q2.20 vector (x, y)
// into atan2(y, x) and the gain-compensated magnitude, both Q3.19.
module cordic_vector #(
  parameter int WIDTH = 22,
  parameter int ITER  = 20,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] angle_out,
  output logic [WIDTH-1:0] mag_out,
  output logic             busy,
  output logic             done
);
  localparam int IW = WIDTH + GUARD + 2;
  localparam int FI = WIDTH - 2 + GUARD;
  localparam int ZW = WIDTH + GUARD + 1;
  localparam int SH = WIDTH + GUARD;
  localparam int PW = IW + WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(IW);
  // atan(2^-i) scaled by 2^21, rounded to nearest
  localparam logic [19:0][31:0] ATAN_Q21 = {
    32'd4, 32'd8, 32'd16, 32'd32, 32'd64, 32'd128, 32'd256, 32'd512,
    32'd1024, 32'd2048, 32'd4096, 32'd8192, 32'd16384, 32'd32765, 32'd65515,
    32'd130902, 32'd260791, 32'd513757, 32'd972340, 32'd1647099};
  localparam logic signed [ZW-1:0] PIZ = ZW'($rtoi(3.14159265358979 * 2.0 ** (WIDTH - 3 + GUARD) + 0.5));
  localparam logic signed [WIDTH:0] PIQ = (WIDTH + 1)'($rtoi(3.14159265358979 * 2.0 ** (WIDTH - 3) + 0.5));
  localparam logic [WIDTH-1:0] INVK = WIDTH'($rtoi(0.6072529350 * 2.0 ** (WIDTH - 1) + 0.5));
  localparam logic signed [ZW-1:0] ZHALF = ZW'(1 << (GUARD - 1));

  typedef enum logic [2:0] {IDLE, PREROT, ITERATE, SCALE, OUT} state_t;
  state_t state;
  logic signed [IW-1:0] x, y, xs, ys;
  logic signed [ZW-1:0] z, a;
  logic [IW-1:0] xa, ya, m;
  logic [SW-1:0] sh, norm;
  logic [CW-1:0] i;
  logic zero, neg_axis;
  logic [WIDTH-1:0] mag, mag_n;
  logic [PW-1:0] prod;
  logic signed [WIDTH:0] zr, ang;

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign a = $signed(ZW'(ATAN_Q21[i]) << (WIDTH + GUARD - 24));
  assign xa = x[IW-1] ? -x : x;
  assign ya = y[IW-1] ? -y : y;
  assign m = xa | ya;
  // Small vectors are scaled up so rounding noise stays tiny relative to them;
  // the angle is scale-free and the magnitude is shifted back in SCALE.
  always_comb begin
    sh = '0;
    for (int k = 0; k < FI; k++) if (m[k]) sh = SW'(FI - k);
    if (|m[IW-1:FI]) sh = '0;
  end
  assign prod = PW'($unsigned(x)) * PW'(INVK);
  assign mag_n = WIDTH'((prod + (PW'(1) << (SH - 1 + norm))) >> (SH + norm));
  assign zr = (WIDTH + 1)'((z + ZHALF) >>> GUARD);
  assign ang = zero ? '0 : neg_axis ? PIQ : zr > PIQ ? PIQ : zr < -PIQ ? -PIQ : zr;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      norm <= '0;
      zero <= 1'b0;
      neg_axis <= 1'b0;
      mag <= '0;
      angle_out <= '0;
      mag_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x <= {{2{x_in[WIDTH-1]}}, x_in, {GUARD{1'b0}}};
          y <= {{2{y_in[WIDTH-1]}}, y_in, {GUARD{1'b0}}};
          busy <= 1'b1;
          state <= PREROT;
        end
        PREROT: begin
          x <= $signed(xa << sh);
          y <= (x[IW-1] ? -y : y) <<< sh;
          z <= !x[IW-1] ? '0 : y[IW-1] ? -PIZ : PIZ;
          norm <= sh;
          zero <= m == '0;
          neg_axis <= x[IW-1] && y == '0;
          i <= '0;
          state <= ITERATE;
        end
        ITERATE: begin
          x <= y[IW-1] ? x - ys : x + ys;
          y <= y[IW-1] ? y + xs : y - xs;
          z <= y[IW-1] ? z - a : z + a;
          i <= i + 1'b1;
          if (i == CW'(ITER - 1)) state <= SCALE;
        end
        SCALE: begin
          mag <= mag_n;
          state <= OUT;
        end
        OUT: begin
          angle_out <= WIDTH'(ang);
          mag_out <= mag;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: directed table, handshake/reset sequences and random
// vectors against a real-valued atan2/hypot model.
module tb_cordic_vector;
  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic [21:0] x_in, y_in, angle_out, mag_out;
  int checks = 0;
  int errors = 0;

  cordic_vector dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .angle_out(angle_out), .mag_out(mag_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] x;
    logic [21:0] y;
    int ang;
    int atol;
    int mag;
    int mtol;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic do_op(input logic [21:0] xv, input logic [21:0] yv, output int ang, output int mag, output int lat);
    @(negedge clk);
    x_in = xv;
    y_in = yv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    ang = $signed(angle_out);
    mag = int'(mag_out);
  endtask

  function automatic real to_r(input logic [21:0] v);
    int t;
    t = $signed(v);
    return t / 1048576.0;
  endfunction

  function automatic int ang_ref(input logic [21:0] xv, input logic [21:0] yv);
    return int'($atan2(to_r(yv), to_r(xv)) * 524288.0);
  endfunction

  function automatic real hyp(input logic [21:0] xv, input logic [21:0] yv);
    return $sqrt(to_r(xv) * to_r(xv) + to_r(yv) * to_r(yv));
  endfunction

  function automatic logic [21:0] rnd_comp();
    int v;
    v = int'($urandom_range(0, 32'h3FFFFF)) - 2097152;
    v = v >>> $urandom_range(0, 11);
    return 22'(v);
  endfunction

  initial begin
    vec_t tbl[9];
    int ang, mag, lat, nd;
    logic [21:0] xv, yv;
    tbl = '{
      '{22'h100000, 22'h000000, 0, 8, 524288, 8},
      '{22'h000000, 22'h100000, 823550, 8, 524288, 8},
      '{22'h000000, 22'h300000, -823550, 8, 524288, 8},
      '{22'h300000, 22'h000000, 1647099, 0, 524288, 8},
      '{22'h100000, 22'h100000, 411775, 8, 741455, 8},
      '{22'h000000, 22'h000000, 0, 0, 0, 0},
      '{22'h200000, 22'h200000, -1235324, 8, 1482910, 8},
      '{22'h000400, 22'h000000, 0, 8, 512, 8},
      '{22'h3FFC00, 22'h000001, 1646587, 8, 512, 8}
    };
    reset = 1'b0;
    start = 1'b0;
    x_in = '0;
    y_in = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0, 0);
    chk("reset done", int'(done), 0, 0);
    chk("reset angle", int'(angle_out), 0, 0);
    chk("reset mag", int'(mag_out), 0, 0);
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      do_op(tbl[k].x, tbl[k].y, ang, mag, lat);
      chk($sformatf("tbl%0d latency", k), lat, 23, 0);
      chk($sformatf("tbl%0d angle", k), ang, tbl[k].ang, tbl[k].atol);
      chk($sformatf("tbl%0d mag", k), mag, tbl[k].mag, tbl[k].mtol);
    end
    // starts while busy must be dropped, not queued
    @(negedge clk);
    x_in = 22'h100000;
    y_in = 22'h100000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy after start", int'(busy), 1, 0);
    x_in = 22'h300000;
    y_in = 22'h000000;
    nd = 0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 10);
      @(negedge clk);
      if (done) begin
        nd++;
        lat = c;
        ang = $signed(angle_out);
        mag = int'(mag_out);
        chk("busy with done", int'(busy), 0, 0);
      end
    end
    start = 1'b0;
    chk("hs done count", nd, 1, 0);
    chk("hs latency", lat, 23, 0);
    chk("hs angle", ang, 411775, 8);
    chk("hs mag", mag, 741455, 8);
    do_op(22'h000000, 22'h100000, ang, mag, lat);
    do_op(22'h300000, 22'h000000, ang, mag, lat);
    chk("b2b latency", lat, 23, 0);
    chk("b2b angle", ang, 1647099, 0);
    chk("b2b mag", mag, 524288, 8);
    for (int n = 0; n < 1500; n++) begin
      do begin
        xv = rnd_comp();
        yv = rnd_comp();
        if ($urandom_range(0, 15) == 0) yv = '0;
        if ($urandom_range(0, 15) == 0) xv = '0;
      end while (hyp(xv, yv) < 1.0 / 1024.0);
      do_op(xv, yv, ang, mag, lat);
      chk($sformatf("rnd%0d latency", n), lat, 23, 0);
      chk($sformatf("rnd%0d angle x=%h y=%h", n, xv, yv), ang, ang_ref(xv, yv), 8);
      chk($sformatf("rnd%0d mag x=%h y=%h", n, xv, yv), mag, int'(hyp(xv, yv) * 524288.0), 8);
    end
    // reset in the middle of the iteration phase
    do_op(22'h100000, 22'h100000, ang, mag, lat);
    @(negedge clk);
    x_in = 22'h300000;
    y_in = 22'h100000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0, 0);
    chk("midrst done", int'(done), 0, 0);
    chk("midrst angle", int'(angle_out), 0, 0);
    chk("midrst mag", int'(mag_out), 0, 0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst no done", nd, 0, 0);
    do_op(22'h100000, 22'h000000, ang, mag, lat);
    chk("post-rst latency", lat, 23, 0);
    chk("post-rst angle", ang, 0, 8);
    chk("post-rst mag", mag, 524288, 8);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule
